// File: rtl/mil_transmitter_pkg.sv
// Shared MIL-STD-1553 word types and the Manchester-II frame encoder.
// The encoder is used by both the transmitter and any model that needs the symbol stream.
package mil_transmitter_pkg;

  typedef enum logic [1:0] {
    WERROR   = 2'b00,
    WCOMMAND = 2'b01,
    WSTATUS  = 2'b10,
    WDATA    = 2'b11
  } MilType;

  typedef struct packed {
    MilType      dataType;
    logic [15:0] dataWord;
  } MilData;

  localparam logic [5:0] SYNC_CMD       = 6'b111000;
  localparam logic [5:0] SYNC_DATA      = 6'b000111;
  localparam int         WORD_HALF_BITS = 40;

  // Bit 39 is the first half-bit on the line; parity is odd over the data word.
  function automatic logic [39:0] milEncode(input MilData d);
    logic [39:0] v;
    logic        p;
    p        = ~^d.dataWord;
    v        = '0;
    v[39:34] = (d.dataType == WDATA) ? SYNC_DATA : SYNC_CMD;
    for (int i = 0; i < 16; i++) begin
      v[33-2*i] = d.dataWord[15-i];
      v[32-2*i] = ~d.dataWord[15-i];
    end
    v[1] = p;
    v[0] = ~p;
    return v;
  endfunction

endpackage

// File: rtl/mil_transmitter_halfbit_timer.sv
// Half-bit symbol timer: tick is high on the last clk of each HALF_BIT_CLKS window.
// restart holds the count at zero so the first window after release is full length.
module mil_halfbit_timer #(
  parameter int HALF_BIT_CLKS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = !restart && (r_cnt == CW'(HALF_BIT_CLKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (restart || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mil_transmitter.sv
// Manchester-II MIL-STD-1553 word transmitter: valid/ready word input, differential line output.
// Words accepted in the last clk of a frame are sent back-to-back; otherwise an idle gap follows.
module mil_transmitter
  import mil_transmitter_pkg::*;
#(
  parameter int HALF_BIT_CLKS = 50,
  parameter int GAP_HALF_BITS = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  MilData in_data,
  output logic   in_ready,
  output logic   tx_p,
  output logic   tx_n,
  output logic   tx_en,
  output logic   busy,
  output logic   drop
);

  localparam int GW = (GAP_HALF_BITS > 1) ? $clog2(GAP_HALF_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [39:0] r_sym;
  logic [5:0]  r_sym_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic        r_drop;

  logic w_tick;
  logic w_last;
  logic w_ready;
  logic w_accept;
  logic w_is_err;

  mil_halfbit_timer #(
    .HALF_BIT_CLKS(HALF_BIT_CLKS)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(r_state == S_IDLE),
    .tick   (w_tick)
  );

  // The only SEND clk that may accept is the final clk of the parity symbol.
  assign w_last   = (r_state == S_SEND) && w_tick && (r_sym_cnt == 6'(WORD_HALF_BITS - 1));
  assign w_ready  = rst && ((r_state == S_IDLE) || w_last);
  assign w_accept = in_valid && w_ready;
  assign w_is_err = (in_data.dataType == WERROR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sym     <= '0;
      r_sym_cnt <= '0;
      r_gap_cnt <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= w_accept && w_is_err;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_is_err) begin
            r_sym     <= milEncode(in_data);
            r_sym_cnt <= '0;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_last) begin
            if (w_accept && !w_is_err) begin
              r_sym     <= milEncode(in_data);
              r_sym_cnt <= '0;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end else if (w_tick) begin
            r_sym     <= {r_sym[38:0], 1'b0};
            r_sym_cnt <= r_sym_cnt + 6'd1;
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_gap_cnt == GW'(GAP_HALF_BITS - 1)) begin
              r_state <= S_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = w_ready;
  assign tx_en    = (r_state == S_SEND);
  assign tx_p     = tx_en & r_sym[39];
  assign tx_n     = tx_en & ~r_sym[39];
  assign busy     = (r_state != S_IDLE);
  assign drop     = r_drop;

endmodule

// File: tb/tb_mil_transmitter.sv
// Self-checking bench for mil_transmitter: directed frame table, gap/contiguity/reset/WERROR
// sequences, and randomized word streams compared against a behavioural line model.
module tb_mil_transmitter;
  import mil_transmitter_pkg::*;

  localparam int HB  = 50;
  localparam int GAP = 8;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   in_valid = 1'b0;
  MilData in_data = '0;
  logic   in_ready, tx_p, tx_n, tx_en, busy, drop;

  int n_cmp = 0;
  int n_bad = 0;

  mil_transmitter #(.HALF_BIT_CLKS(HB), .GAP_HALF_BITS(GAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_p(tx_p), .tx_n(tx_n), .tx_en(tx_en), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line model: half-bit stream as a 40-bit vector, first symbol in bit 39.
  function automatic logic [31:0] manch(input logic [15:0] w);
    logic [31:0] m = '0;
    for (int i = 15; i >= 0; i--) m = {m[29:0], w[i], ~w[i]};
    return m;
  endfunction

  function automatic logic [39:0] model_frame(input MilData d);
    int   ones = 0;
    logic par;
    logic [5:0] sync;
    for (int i = 0; i < 16; i++) ones += int'(d.dataWord[i]);
    par  = (ones % 2 == 0);
    sync = (d.dataType == WDATA) ? 6'b000111 : 6'b111000;
    return {sync, manch(d.dataWord), par, ~par};
  endfunction

  function automatic MilData mk(input MilType t, input logic [15:0] w);
    MilData d;
    d.dataType = t;
    d.dataWord = w;
    return d;
  endfunction

  task automatic send_from_idle(input MilData d);
    int t = 0;
    while (in_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the first clk of a frame; leaves the bench on the first clk after it.
  task automatic expect_frame(input logic [39:0] f, input string tag, input bit hold_valid,
                              input bit next_valid, input MilData next_d);
    bit ok;
    bit last;
    logic sym;
    for (int h = 0; h < 40; h++) begin
      ok  = 1'b1;
      sym = f[39-h];
      for (int c = 0; c < HB; c++) begin
        last = (h == 39) && (c == HB - 1);
        if (tx_en !== 1'b1 || tx_p !== sym || tx_n !== ~sym || busy !== 1'b1) ok = 1'b0;
        if (in_ready !== last) ok = 1'b0;
        if (last) begin
          in_valid = next_valid;
          in_data  = next_d;
        end else if (hold_valid) begin
          in_valid = 1'b1;
          in_data  = MilData'(18'($urandom));
        end
        @(negedge clk);
      end
      check($sformatf("%s_sym%0d", tag, h), ok, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_gap(input string tag);
    bit ok = 1'b1;
    for (int c = 0; c < GAP * HB; c++) begin
      if (tx_en !== 1'b0 || tx_p !== 1'b0 || tx_n !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
        ok = 1'b0;
      @(negedge clk);
    end
    check({tag, "_gap"}, ok, 1);
    check({tag, "_gap_end"}, {in_ready, busy, tx_en}, 3'b100);
  endtask

  typedef struct {
    MilType      t;
    logic [15:0] w;
    bit          contig;
    logic [5:0]  sync;
    logic        par;
  } vec_t;

  initial begin
    vec_t   tbl[5];
    MilData cur, nd, d0, d1;
    bit     nxt, nc, in_idle;
    logic [39:0] f;
    int     k;

    tbl[0] = '{WCOMMAND, 16'h0A5F, 1'b0, 6'b111000, 1'b1};
    tbl[1] = '{WDATA,    16'hFFFF, 1'b1, 6'b000111, 1'b1};
    tbl[2] = '{WSTATUS,  16'h0001, 1'b0, 6'b111000, 1'b0};
    tbl[3] = '{WDATA,    16'h0000, 1'b0, 6'b000111, 1'b1};
    tbl[4] = '{WCOMMAND, 16'h8000, 1'b1, 6'b111000, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, tx_p, tx_n, tx_en, busy, drop}, 6'b000000);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset", {in_ready, busy, tx_en}, 3'b100);

    for (int i = 0; i < 5; i++) begin
      f = {tbl[i].sync, manch(tbl[i].w), tbl[i].par, ~tbl[i].par};
      if (!tbl[i].contig) send_from_idle(mk(tbl[i].t, tbl[i].w));
      nxt = (i + 1 < 5) ? tbl[i+1].contig : 1'b0;
      nd  = nxt ? mk(tbl[i+1].t, tbl[i+1].w) : MilData'(18'h0);
      expect_frame(f, $sformatf("tbl%0d", i), 1'b0, nxt, nd);
      if (!nxt) expect_gap($sformatf("tbl%0d", i));
    end

    // WERROR in IDLE is swallowed with a single drop pulse.
    in_valid = 1'b1;
    in_data  = mk(WERROR, 16'h1234);
    @(negedge clk);
    in_valid = 1'b0;
    check("werr_drop", {drop, tx_en, busy}, 3'b100);
    @(negedge clk);
    check("werr_after", {drop, tx_en, busy, in_ready}, 4'b0001);

    // Input data churning every clk: only the accept-clk snapshots may reach the line.
    d0 = mk(WCOMMAND, 16'($urandom));
    d1 = mk(WDATA, 16'($urandom));
    send_from_idle(d0);
    expect_frame(model_frame(d0), "hold0", 1'b1, 1'b1, d1);
    expect_frame(model_frame(d1), "hold1", 1'b1, 1'b0, MilData'(18'h0));
    expect_gap("hold");

    cur     = mk(MilType'(2'($urandom_range(1, 3))), 16'($urandom));
    in_idle = 1'b1;
    k       = 0;
    while (k < 10) begin
      if (in_idle) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_from_idle(cur);
      end
      nc = (k < 9) && ($urandom_range(0, 1) == 1);
      nd = mk(MilType'(2'($urandom_range(1, 3))), 16'($urandom));
      expect_frame(model_frame(cur), $sformatf("rnd%0d", k), 1'b0, nc, nd);
      if (!nc) expect_gap($sformatf("rnd%0d", k));
      cur     = nd;
      in_idle = !nc;
      k++;
    end

    // Asynchronous reset in the middle of a frame.
    send_from_idle(mk(WCOMMAND, 16'h0A5F));
    repeat (300) @(negedge clk);
    check("mid_send_active", {tx_en, busy}, 2'b11);
    rst = 1'b0;
    #1;
    check("async_reset", {tx_p, tx_n, tx_en, busy, in_ready}, 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_release", {in_ready, busy, tx_en}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
